// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM state
// encodings and the PC field widths used to split offset, index and tag.
package instruction_cache_pkg;

  localparam int OFFSET_BITS = 2;
  localparam int INDEX_BITS  = 3;
  localparam int TAG_BITS    = 3;
  localparam int BLOCK_BITS  = TAG_BITS + INDEX_BITS;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_READ = 2'd1,
    ST_UPDATE   = 2'd2
  } icache_state_e;

endpackage

// File: rtl/icache_word_select.sv
// Combinational 128-to-32 word mux: picks one instruction word out of a
// cache line using the PC word offset (word 0 lives in bits [31:0]).
module icache_word_select
  import instruction_cache_pkg::*;
(
  input  logic [127:0]           line,
  input  logic [OFFSET_BITS-1:0] offset,
  output logic [31:0]            word
);

  // Offset-driven word mux
  always_comb begin
    word = 32'h0000_0000;
    case (offset)
      2'd0:    word = line[31:0];
      2'd1:    word = line[63:32];
      2'd2:    word = line[95:64];
      2'd3:    word = line[127:96];
      default: word = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/instruction_cache.sv
// Read-only direct-mapped instruction cache with zero-cycle hits and a
// three-state refill FSM (IDLE -> MEM_READ -> UPDATE) towards block memory.
module instruction_cache
  import instruction_cache_pkg::*;
#(
  parameter int NUM_BLOCKS      = 8,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int ADDR_BITS       = 10
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [31:0]                PC,
  output logic [31:0]                INSTRUCTION,
  output logic                       BUSYWAIT,
  output logic                       MEM_READ,
  output logic [BLOCK_BITS-1:0]      MEM_ADDRESS,
  input  logic [WORDS_PER_BLOCK*32-1:0] MEM_READDATA,
  input  logic                       MEM_BUSYWAIT
);

  localparam int LINE_BITS = WORDS_PER_BLOCK * 32;

  logic [OFFSET_BITS-1:0] offset_s;
  logic [INDEX_BITS-1:0]  index_s;
  logic [TAG_BITS-1:0]    tag_s;
  logic                   unused_pc_s;

  logic [NUM_BLOCKS-1:0]  valid_r;
  logic [TAG_BITS-1:0]    tag_mem_r  [NUM_BLOCKS];
  logic [LINE_BITS-1:0]   data_mem_r [NUM_BLOCKS];

  icache_state_e          state_r;
  icache_state_e          state_s;
  logic [INDEX_BITS-1:0]  index_r;
  logic [TAG_BITS-1:0]    tag_r;
  logic [LINE_BITS-1:0]   fill_data_r;
  logic                   mem_read_r;
  logic [BLOCK_BITS-1:0]  mem_addr_r;
  logic [BLOCK_BITS-1:0]  lat_addr_s;

  logic                   hit_s;
  logic                   busy_s;
  logic [LINE_BITS-1:0]   line_s;
  logic [31:0]            word_s;

  // Upper PC bits alias onto the 1 KiB instruction space; byte bits are ignored
  assign offset_s    = PC[OFFSET_BITS+1:2];
  assign index_s     = PC[OFFSET_BITS+INDEX_BITS+1:OFFSET_BITS+2];
  assign tag_s       = PC[ADDR_BITS-1:ADDR_BITS-TAG_BITS];
  assign unused_pc_s = ^{PC[31:ADDR_BITS], PC[1:0]};

  assign hit_s  = valid_r[index_s] && (tag_mem_r[index_s] == tag_s);
  assign line_s = data_mem_r[index_s];

  icache_word_select u_word_select (
    .line   (line_s),
    .offset (offset_s),
    .word   (word_s)
  );

  // Next-state decode and stall request
  always_comb begin
    state_s = state_r;
    busy_s  = 1'b1;
    case (state_r)
      ST_IDLE: begin
        if (hit_s) begin
          busy_s  = 1'b0;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_MEM_READ;
        end
      end
      ST_MEM_READ: begin
        if (MEM_BUSYWAIT) begin
          state_s = ST_MEM_READ;
        end else begin
          state_s = ST_UPDATE;
        end
      end
      ST_UPDATE: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Block address for the refill: fresh PC fields on the miss edge, latched afterwards
  always_comb begin
    if (state_r == ST_IDLE) begin
      lat_addr_s = {tag_s, index_s};
    end else begin
      lat_addr_s = {tag_r, index_r};
    end
  end

  // FSM, refill bookkeeping, valid bits and registered memory request
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_r     <= ST_IDLE;
      valid_r     <= '0;
      index_r     <= '0;
      tag_r       <= '0;
      fill_data_r <= '0;
      mem_read_r  <= 1'b0;
      mem_addr_r  <= '0;
    end else begin
      state_r    <= state_s;
      mem_read_r <= (state_s == ST_MEM_READ);
      mem_addr_r <= (state_s == ST_MEM_READ) ? lat_addr_s : '0;
      if (state_r == ST_IDLE && !hit_s) begin
        index_r <= index_s;
        tag_r   <= tag_s;
      end
      if (state_r == ST_MEM_READ && !MEM_BUSYWAIT) begin
        fill_data_r <= MEM_READDATA;
      end
      if (state_r == ST_UPDATE) begin
        valid_r[index_r] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them
  always_ff @(posedge CLK) begin
    if (RESET && state_r == ST_UPDATE) begin
      tag_mem_r[index_r]  <= tag_r;
      data_mem_r[index_r] <= fill_data_r;
    end
  end

  assign BUSYWAIT    = busy_s;
  assign MEM_READ    = mem_read_r;
  assign MEM_ADDRESS = mem_addr_r;
  assign INSTRUCTION = (RESET && state_r == ST_IDLE && hit_s) ? word_s : 32'h0000_0000;

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: a behavioural block memory with a
// programmable busy count, a hit-vector table and hand-written refill sequences.
module tb_instruction_cache;

  logic         CLK;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_n   = 3;
  int mem_cnt  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t tbl [9];

  instruction_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [5:0] blk, input logic [1:0] w);
    return {8'hA5, 2'b00, blk, 8'h3C, 6'b000000, w};
  endfunction

  // Memory stays busy for busy_n cycles of an active read, then returns the block
  always @(posedge CLK) begin
    if (MEM_READ) mem_cnt <= mem_cnt + 1;
    else          mem_cnt <= 0;
  end

  assign MEM_BUSYWAIT = MEM_READ && (mem_cnt < busy_n);
  assign MEM_READDATA = {mem_word(MEM_ADDRESS, 2'd3), mem_word(MEM_ADDRESS, 2'd2),
                         mem_word(MEM_ADDRESS, 2'd1), mem_word(MEM_ADDRESS, 2'd0)};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Step negedges until BUSYWAIT drops; counts stalled cycles after the request cycle
  task automatic wait_idle(output int cyc, input logic [5:0] blk);
    bit done;
    cyc  = 0;
    done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      if (!BUSYWAIT) begin
        done = 1'b1;
        break;
      end
      cyc++;
      if (MEM_READ) check("mem_address", {26'd0, MEM_ADDRESS}, {26'd0, blk});
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL refill_timeout: BUSYWAIT still 1 after 60 cycles, expected 0");
    end
  endtask

  task automatic do_miss(input logic [31:0] pc, input int n, input int exp_cyc,
                         input logic [5:0] blk);
    int cyc;
    busy_n = n;
    PC     = pc;
    #1;
    check("miss_detect", {31'd0, BUSYWAIT}, 32'd1);
    wait_idle(cyc, blk);
    check("miss_penalty", cyc, exp_cyc);
    check("refill_instr", INSTRUCTION, mem_word(blk, pc[3:2]));
  endtask

  task automatic check_hit(input logic [31:0] pc, input logic [31:0] exp);
    @(negedge CLK);
    PC = pc;
    #1;
    check("hit_busywait", {31'd0, BUSYWAIT}, 32'd0);
    check("hit_instr", INSTRUCTION, exp);
  endtask

  initial begin
    bit ok;
    int cyc;

    tbl[0] = '{32'h0000_0004, mem_word(6'h00, 2'd1)};
    tbl[1] = '{32'h0000_0008, mem_word(6'h00, 2'd2)};
    tbl[2] = '{32'h0000_000C, mem_word(6'h00, 2'd3)};
    tbl[3] = '{32'h0000_0001, mem_word(6'h00, 2'd0)};
    tbl[4] = '{32'h0000_0400, mem_word(6'h00, 2'd0)};
    tbl[5] = '{32'h0000_03F8, mem_word(6'h3F, 2'd2)};
    tbl[6] = '{32'hFFFF_FFF0, mem_word(6'h3F, 2'd0)};
    tbl[7] = '{32'hABCD_E3F4, mem_word(6'h3F, 2'd1)};
    tbl[8] = '{32'hFFFF_FFFC, mem_word(6'h3F, 2'd3)};

    RESET = 1'b0;
    PC    = 32'h0000_0000;
    repeat (3) @(negedge CLK);
    check("reset_mem_read", {31'd0, MEM_READ}, 32'd0);
    check("reset_mem_addr", {26'd0, MEM_ADDRESS}, 32'd0);
    check("reset_instr", INSTRUCTION, 32'd0);
    RESET = 1'b1;

    // First fetch misses; 3 busy cycles -> 5 stalled cycles
    do_miss(32'h0000_0000, 3, 5, 6'h00);
    // Pre-reset PC value is plain address 0x3FC; zero-wait memory -> 2 cycles
    do_miss(32'hFFFF_FFFC, 0, 2, 6'h3F);

    for (int i = 0; i < 9; i++) check_hit(tbl[i].pc, tbl[i].instr);

    // Conflict on index 0: tag 1 evicts tag 0, which then misses again
    @(negedge CLK);
    do_miss(32'h0000_0080, 1, 3, 6'h08);
    @(negedge CLK);
    do_miss(32'h0000_0000, 2, 4, 6'h00);

    // PC moves during the 0x010 refill; the latched block still governs it
    @(negedge CLK);
    busy_n = 3;
    PC     = 32'h0000_0010;
    #1;
    check("r42_miss", {31'd0, BUSYWAIT}, 32'd1);
    @(negedge CLK);
    check("r42_mem_read", {31'd0, MEM_READ}, 32'd1);
    check("r42_addr", {26'd0, MEM_ADDRESS}, 32'h01);
    PC = 32'h0000_0020;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (!MEM_READ) begin
        ok = 1'b1;
        break;
      end
      check("r42_addr_hold", {26'd0, MEM_ADDRESS}, 32'h01);
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL r42_timeout: MEM_READ still 1 after 20 cycles, expected 0");
    end
    check("r42_update_busy", {31'd0, BUSYWAIT}, 32'd1);
    @(negedge CLK);
    check("r42_new_miss", {31'd0, BUSYWAIT}, 32'd1);
    check("r42_idle_no_read", {31'd0, MEM_READ}, 32'd0);
    busy_n = 0;
    wait_idle(cyc, 6'h02);
    check("r42_line2_penalty", cyc, 32'd2);
    check("r42_line2_instr", INSTRUCTION, mem_word(6'h02, 2'd0));
    check_hit(32'h0000_0014, mem_word(6'h01, 2'd1));
    check_hit(32'h0000_001C, mem_word(6'h01, 2'd3));

    // Reset during MEM_READ abandons the refill and clears every line
    @(negedge CLK);
    busy_n = 3;
    PC     = 32'h0000_0030;
    #1;
    check("r41_miss", {31'd0, BUSYWAIT}, 32'd1);
    @(negedge CLK);
    check("r41_mem_read", {31'd0, MEM_READ}, 32'd1);
    RESET = 1'b0;
    @(negedge CLK);
    check("r41_abandon_read", {31'd0, MEM_READ}, 32'd0);
    check("r41_abandon_addr", {26'd0, MEM_ADDRESS}, 32'd0);
    check("r41_abandon_instr", INSTRUCTION, 32'd0);
    RESET = 1'b1;
    do_miss(32'h0000_0030, 3, 5, 6'h03);
    @(negedge CLK);
    do_miss(32'h0000_0000, 0, 2, 6'h00);
    @(negedge CLK);
    do_miss(32'h0000_0014, 0, 2, 6'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "watchdog");
  end

endmodule
